// File: rtl/cache_arbiter.sv
// ---------------------------------------------------------------------------
// cache_arbiter
//
// Purpose:
//   Shares the single L2/physical-memory port between the L1 instruction
//   cache and the L1 data cache. Line-granularity misses and writebacks from
//   both caches are serialized with a round-robin policy, the L2 completion is
//   routed back only to the cache that currently holds the grant, and a
//   saturating count of IDLE-cycle conflicts is kept for performance counters.
//
// Ports:
//   clk, reset             system clock; synchronous active-high reset
//   i_read, i_address      L1I line read request (held until i_resp)
//   i_resp, i_rdata        L1I completion pulse and returned line
//   d_read, d_write        L1D line read / writeback request (held until d_resp)
//   d_address, d_wdata     L1D line address and writeback data
//   d_resp, d_rdata        L1D completion pulse and returned line
//   l2_read, l2_write      request strobes towards L2
//   l2_address, l2_wdata   address and write line towards L2
//   l2_resp, l2_rdata      L2 completion pulse and read line
//   conflict_count         saturating count of IDLE cycles with both requesting
// ---------------------------------------------------------------------------
module cache_arbiter #(
  parameter int LINE_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_read,
  input  logic [31:0]           i_address,
  output logic                  i_resp,
  output logic [LINE_WIDTH-1:0] i_rdata,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [31:0]           d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic                  d_resp,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  l2_read,
  output logic                  l2_write,
  output logic [31:0]           l2_address,
  output logic [LINE_WIDTH-1:0] l2_wdata,
  input  logic                  l2_resp,
  input  logic [LINE_WIDTH-1:0] l2_rdata,
  output logic [31:0]           conflict_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } arbState_t;

  arbState_t   r_state;
  arbState_t   w_nextState;
  logic        r_lastGrant;
  logic [31:0] r_conflictCount;

  logic        w_reqI;
  logic        w_reqD;
  logic        w_tie;

  // A data-side request is either a line fill or a writeback; a tie is only
  // meaningful when both caches want the port at the same time.
  assign w_reqI = i_read;
  assign w_reqD = d_read | d_write;
  assign w_tie  = w_reqI & w_reqD;

  // The returned line is broadcast to both caches; only the matching resp
  // strobe tells a cache that the data belongs to it.
  assign i_rdata        = l2_rdata;
  assign d_rdata        = l2_rdata;
  assign conflict_count = r_conflictCount;

  // State register, round-robin pointer and conflict counter. last_grant
  // resets to the data side so that the very first tie goes to the
  // instruction cache. The pointer only moves when a new grant is issued out
  // of IDLE, and the conflict counter sticks at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= IDLE;
      r_lastGrant     <= 1'b1;
      r_conflictCount <= 32'd0;
    end else begin
      r_state <= w_nextState;
      if ((r_state == IDLE) && (w_nextState != IDLE)) begin
        r_lastGrant <= (w_nextState == GRANT_D);
      end
      if ((r_state == IDLE) && w_tie && (r_conflictCount != 32'hFFFF_FFFF)) begin
        r_conflictCount <= r_conflictCount + 32'd1;
      end
    end
  end

  // Next-state and output decode. IDLE picks a winner (opposite of the last
  // grant on a tie) and drives nothing towards L2, so a stray l2_resp there is
  // ignored. A grant is held until l2_resp even if the requester lets go, and
  // the completion is passed straight through in the same cycle. On the data
  // side a writeback takes priority over a read if both are raised.
  always_comb begin
    w_nextState = r_state;
    l2_read     = 1'b0;
    l2_write    = 1'b0;
    l2_address  = 32'd0;
    l2_wdata    = '0;
    i_resp      = 1'b0;
    d_resp      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_tie) begin
          w_nextState = r_lastGrant ? GRANT_I : GRANT_D;
        end else if (w_reqI) begin
          w_nextState = GRANT_I;
        end else if (w_reqD) begin
          w_nextState = GRANT_D;
        end
      end
      GRANT_I: begin
        l2_read    = 1'b1;
        l2_address = i_address;
        i_resp     = l2_resp;
        if (l2_resp) begin
          w_nextState = IDLE;
        end
      end
      GRANT_D: begin
        l2_read    = d_read & ~d_write;
        l2_write   = d_write;
        l2_address = d_address;
        l2_wdata   = d_wdata;
        d_resp     = l2_resp;
        if (l2_resp) begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cache_arbiter
//
// Directed scenarios followed by a randomized soak. The bench plays both L1
// requesters and the L2, and keeps a transaction-level reference of who owns
// the L2 port, who was served last and how many conflicts were seen.
// ---------------------------------------------------------------------------
module tb_cache_arbiter;

  localparam int LW = 256;

  logic          clk = 1'b0;
  logic          reset;
  logic          iRead;
  logic [31:0]   iAddress;
  logic          iResp;
  logic [LW-1:0] iRdata;
  logic          dRead;
  logic          dWrite;
  logic [31:0]   dAddress;
  logic [LW-1:0] dWdata;
  logic          dResp;
  logic [LW-1:0] dRdata;
  logic          l2Read;
  logic          l2Write;
  logic [31:0]   l2Address;
  logic [LW-1:0] l2Wdata;
  logic          l2Resp;
  logic [LW-1:0] l2Rdata;
  logic [31:0]   conflictCount;

  cache_arbiter #(.LINE_WIDTH(LW)) dut (
    .clk            (clk),
    .reset          (reset),
    .i_read         (iRead),
    .i_address      (iAddress),
    .i_resp         (iResp),
    .i_rdata        (iRdata),
    .d_read         (dRead),
    .d_write        (dWrite),
    .d_address      (dAddress),
    .d_wdata        (dWdata),
    .d_resp         (dResp),
    .d_rdata        (dRdata),
    .l2_read        (l2Read),
    .l2_write       (l2Write),
    .l2_address     (l2Address),
    .l2_wdata       (l2Wdata),
    .l2_resp        (l2Resp),
    .l2_rdata       (l2Rdata),
    .conflict_count (conflictCount)
  );

  // Free-running clock; inputs change and outputs are sampled on the falling edge.
  always #5 clk = ~clk;

  int testsRun  = 0;
  int failCount = 0;
  int cycleNum  = 0;

  // Reference: owner of the L2 port (0 none, 1 I, 2 D), who was served last,
  // conflict tally, and how long the current owner has been waiting on L2.
  int          mOwner;
  bit          mLastWasD;
  logic [31:0] mConflicts;
  int          mAge;
  bit          mIRespLast;
  bit          mDRespLast;

  // Agent controls: requester mode 0 one-shot, 1 continuous, 2 random.
  int            iMode;
  int            dMode;
  int            l2Latency;
  int            l2FixedLatency;
  bit            spuriousOn;
  bit            l2ForceResp;
  bit            l2UsePattern;
  logic [LW-1:0] l2Pattern;

  // Observations of DUT behaviour for scenario-level checks.
  int            respLog[$];
  int            l2StartCycles[$];
  int            iRespSeen;
  int            dRespSeen;
  int            bothRespSeen;
  int            iRespCycle;
  logic [LW-1:0] iRdataCap;
  logic          capRead;
  logic          capWrite;
  logic [LW-1:0] capWdata;
  logic [31:0]   capAddr;
  bit            prevActive;

  function automatic logic [LW-1:0] rand256();
    logic [LW-1:0] v;
    for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic int qAt(input int q[$], input int idx);
    if (idx < q.size()) return q[idx];
    return -1;
  endfunction

  task automatic checkOutput(input string tag, input logic [LW-1:0] observed,
                             input logic [LW-1:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drives both requesters and the L2 for the current cycle.
  task automatic applyStimulus();
    if (mIRespLast && iMode != 1) iRead = 1'b0;
    if (mDRespLast && dMode != 1) begin
      dRead  = 1'b0;
      dWrite = 1'b0;
    end
    if (iMode == 2 && !iRead && $urandom_range(0, 3) == 0) begin
      iRead    = 1'b1;
      iAddress = $urandom;
    end
    if (dMode == 2 && !dRead && !dWrite && $urandom_range(0, 3) == 0) begin
      case ($urandom_range(0, 2))
        0:       dRead = 1'b1;
        1:       dWrite = 1'b1;
        default: begin dRead = 1'b1; dWrite = 1'b1; end
      endcase
      dAddress = $urandom;
      dWdata   = rand256();
    end
    l2Rdata = rand256();
    if (mOwner != 0) begin
      l2Resp = (mAge == l2Latency);
      if (l2Resp && l2UsePattern) l2Rdata = l2Pattern;
    end else begin
      l2Resp = l2ForceResp || (spuriousOn && $urandom_range(0, 3) == 0);
    end
  endtask

  // One clock cycle: drive, check every output against the reference, record
  // what happened, then advance the reference across the coming rising edge.
  task automatic runCycle();
    bit            expRead;
    bit            expWrite;
    bit            expIResp;
    bit            expDResp;
    bit            wantI;
    bit            wantD;
    logic [31:0]   expAddr;
    logic [LW-1:0] expWdata;
    applyStimulus();
    #1;
    expRead  = (mOwner == 1) || (mOwner == 2 && dRead && !dWrite);
    expWrite = (mOwner == 2) && dWrite;
    expAddr  = (mOwner == 1) ? iAddress : (mOwner == 2) ? dAddress : 32'd0;
    expWdata = (mOwner == 2) ? dWdata : '0;
    expIResp = (mOwner == 1) && l2Resp;
    expDResp = (mOwner == 2) && l2Resp;
    checkOutput("l2_read", l2Read, expRead);
    checkOutput("l2_write", l2Write, expWrite);
    checkOutput("l2_address", l2Address, expAddr);
    checkOutput("l2_wdata", l2Wdata, expWdata);
    checkOutput("i_resp", iResp, expIResp);
    checkOutput("d_resp", dResp, expDResp);
    checkOutput("i_rdata", iRdata, l2Rdata);
    checkOutput("d_rdata", dRdata, l2Rdata);
    checkOutput("conflict_count", conflictCount, mConflicts);

    if (iResp === 1'b1) begin
      iRespSeen++;
      iRespCycle = cycleNum;
      iRdataCap  = iRdata;
      respLog.push_back(1);
    end
    if (dResp === 1'b1) begin
      dRespSeen++;
      capRead  = l2Read;
      capWrite = l2Write;
      capWdata = l2Wdata;
      capAddr  = l2Address;
      respLog.push_back(2);
    end
    if (iResp === 1'b1 && dResp === 1'b1) bothRespSeen++;
    if ((l2Read === 1'b1 || l2Write === 1'b1) && !prevActive) l2StartCycles.push_back(cycleNum);
    prevActive = (l2Read === 1'b1 || l2Write === 1'b1);

    mIRespLast = expIResp;
    mDRespLast = expDResp;
    if (reset) begin
      mOwner     = 0;
      mLastWasD  = 1'b1;
      mConflicts = 32'd0;
    end else if (mOwner != 0) begin
      if (l2Resp) mOwner = 0;
      else mAge++;
    end else begin
      wantI = iRead;
      wantD = dRead || dWrite;
      if (wantI && wantD) begin
        if (mConflicts != 32'hFFFF_FFFF) mConflicts++;
        mOwner = mLastWasD ? 1 : 2;
      end else if (wantI) begin
        mOwner = 1;
      end else if (wantD) begin
        mOwner = 2;
      end
      if (mOwner != 0) begin
        mLastWasD = (mOwner == 2);
        mAge      = 0;
        l2Latency = (l2FixedLatency >= 0) ? l2FixedLatency : int'($urandom_range(0, 4));
      end
    end
    cycleNum++;
    @(negedge clk);
  endtask

  initial begin
    logic [LW-1:0] patA;
    logic [LW-1:0] patB;
    int            startCycle;
    int            baseI;
    int            baseD;

    patA = {8{32'hA5A5_0001}};
    patB = {8{32'hB00B_CAFE}};
    reset = 1'b1; iRead = 1'b0; iAddress = 32'd0; dRead = 1'b0; dWrite = 1'b0;
    dAddress = 32'd0; dWdata = '0; l2Resp = 1'b0; l2Rdata = '0;
    iMode = 0; dMode = 0; l2Latency = 0; l2FixedLatency = 3; spuriousOn = 1'b0;
    l2ForceResp = 1'b0; l2UsePattern = 1'b0; l2Pattern = '0;
    mOwner = 0; mLastWasD = 1'b1; mConflicts = 32'd0; mAge = 0;
    mIRespLast = 1'b0; mDRespLast = 1'b0;
    iRespSeen = 0; dRespSeen = 0; bothRespSeen = 0; iRespCycle = -1; iRdataCap = '0;
    capRead = 1'b0; capWrite = 1'b0; capWdata = '0; capAddr = 32'd0; prevActive = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    #1;
    checkOutput("reset_l2_read", l2Read, 1'b0);
    checkOutput("reset_l2_write", l2Write, 1'b0);
    checkOutput("reset_conflicts", conflictCount, 32'd0);

    // Single instruction fetch, L2 answers three cycles after the read rises
    $display("[TB] step 1: instruction line read");
    reset = 1'b0; l2FixedLatency = 3; l2UsePattern = 1'b1; l2Pattern = patA;
    iRead = 1'b1; iAddress = 32'h0000_0100;
    respLog.delete(); l2StartCycles.delete();
    startCycle = cycleNum; baseI = iRespSeen; baseD = dRespSeen;
    repeat (8) runCycle();
    checkOutput("t1_l2_read_start", qAt(l2StartCycles, 0), startCycle + 1);
    checkOutput("t1_i_resp_cycle", iRespCycle, startCycle + 4);
    checkOutput("t1_i_resp_count", iRespSeen - baseI, 1);
    checkOutput("t1_d_resp_count", dRespSeen - baseD, 0);
    checkOutput("t1_i_rdata", iRdataCap, patA);
    l2UsePattern = 1'b0;

    // Data writeback
    $display("[TB] step 2: data line writeback");
    dWrite = 1'b1; dAddress = 32'h0000_2000; dWdata = patB;
    baseI = iRespSeen; baseD = dRespSeen;
    repeat (8) runCycle();
    checkOutput("t2_d_resp_count", dRespSeen - baseD, 1);
    checkOutput("t2_i_resp_count", iRespSeen - baseI, 0);
    checkOutput("t2_l2_write", capWrite, 1'b1);
    checkOutput("t2_l2_read", capRead, 1'b0);
    checkOutput("t2_l2_wdata", capWdata, patB);
    checkOutput("t2_l2_address", capAddr, 32'h0000_2000);

    // Simultaneous requests straight out of reset
    $display("[TB] step 3: tie after reset");
    reset = 1'b1;
    runCycle();
    reset = 1'b0; l2FixedLatency = 2;
    iRead = 1'b1; iAddress = 32'h0000_0300;
    dRead = 1'b1; dAddress = 32'h0000_4000;
    respLog.delete(); l2StartCycles.delete();
    repeat (14) runCycle();
    checkOutput("t3_resp_count", respLog.size(), 2);
    checkOutput("t3_first_grant", qAt(respLog, 0), 1);
    checkOutput("t3_second_grant", qAt(respLog, 1), 2);
    checkOutput("t3_conflicts", conflictCount, 32'd1);
    checkOutput("t3_d_gap", qAt(l2StartCycles, 1) - iRespCycle, 2);

    // Both requesters held high: grants must alternate
    $display("[TB] step 4: continuous contention");
    iMode = 1; dMode = 1; l2FixedLatency = -1;
    iRead = 1'b1; dRead = 1'b1; dWrite = 1'b0;
    respLog.delete(); bothRespSeen = 0;
    for (int k = 0; k < 200 && respLog.size() < 6; k++) runCycle();
    for (int k = 0; k < 6; k++) begin
      checkOutput("t4_grant_order", qAt(respLog, k), (k % 2 == 0) ? 1 : 2);
    end
    checkOutput("t4_double_resp", bothRespSeen, 0);
    iMode = 0; dMode = 0;
    repeat (20) runCycle();

    // Reset while the data side is mid-transaction, then a late L2 response
    $display("[TB] step 5: reset during data grant");
    l2FixedLatency = 6;
    dRead = 1'b1; dAddress = 32'h0000_5000;
    repeat (3) runCycle();
    checkOutput("t5_pre_l2_read", l2Read, 1'b1);
    baseD = dRespSeen;
    reset = 1'b1; dRead = 1'b0;
    runCycle();
    reset = 1'b0; l2ForceResp = 1'b1;
    runCycle();
    checkOutput("t5_l2_read", l2Read, 1'b0);
    checkOutput("t5_l2_write", l2Write, 1'b0);
    checkOutput("t5_d_resp", dResp, 1'b0);
    checkOutput("t5_conflicts", conflictCount, 32'd0);
    checkOutput("t5_d_resp_count", dRespSeen - baseD, 0);
    l2ForceResp = 1'b0;
    repeat (3) runCycle();

    // Counter saturation
    $display("[TB] step 6: conflict counter saturation");
    dut.r_conflictCount = 32'hFFFF_FFFD;
    mConflicts = 32'hFFFF_FFFD;
    iMode = 1; dMode = 1; l2FixedLatency = 0;
    iRead = 1'b1; dRead = 1'b1;
    respLog.delete();
    for (int k = 0; k < 100 && respLog.size() < 6; k++) runCycle();
    checkOutput("t6_saturated", conflictCount, 32'hFFFF_FFFF);
    iMode = 0; dMode = 0;
    repeat (10) runCycle();
    checkOutput("t6_no_wrap", conflictCount, 32'hFFFF_FFFF);

    // Randomized soak with random latencies, stray responses and resets
    $display("[TB] step 7: random traffic");
    reset = 1'b1;
    runCycle();
    reset = 1'b0; iMode = 2; dMode = 2; spuriousOn = 1'b1; l2FixedLatency = -1;
    for (int k = 0; k < 1500; k++) begin
      reset = ($urandom_range(0, 149) == 0);
      runCycle();
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
